pipelined_adder: RTL and testbench

- Parametrised, pipelined successor to the team's K-bit carry-ripple adder.
- Splits a K-bit add into STAGES chunks, with one chunk ripple per clock and the carry registered between stages.
- Uses a valid/ready handshake with per-stage backpressure and bubble collapse.
- Used in datapaths where a full K-bit ripple misses timing and throughput of one op per cycle is required.

---
 rtl/pipelined_adder.sv | 137 +++++++++++++
 tb/tb_pipelined_adder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// K-bit adder split into STAGES chunk stages with a registered carry between stages and
// valid/ready flow control. Optional PIPELINED_ADDER_SUB_EN macro adds a per-beat subtract port.
module pipelined_adder #(
    parameter int K      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K:0]   sum
);

    localparam int W = K / STAGES;

    // Bit mask covering chunk s of a K-bit word.
    function automatic logic [K-1:0] chunk_mask(input int s);
        logic [K-1:0] low;
        low = (K'(1'b1) << W) - K'(1'b1);
        return low << (s * W);
    endfunction

    // acc_r holds finished result chunks 0..s in its low part and still-pending
    // operand A chunks above; bop_r carries operand B alongside.
    logic [STAGES-1:0] v_r;
    logic [STAGES-1:0] c_r;
    logic [K-1:0]      acc_r [STAGES];
    logic [K-1:0]      bop_r [STAGES];

    logic [STAGES-1:0] rdy_s;
    logic [STAGES-1:0] v_in_s;
    logic [STAGES-1:0] c_in_s;
    logic [STAGES-1:0] c_nx_s;
    logic [K-1:0]      acc_in_s [STAGES];
    logic [K-1:0]      bop_in_s [STAGES];
    logic [K-1:0]      acc_nx_s [STAGES];
    logic [W:0]        part_s   [STAGES];
    logic [K-1:0]      b_eff_s;
    logic              cin_eff_s;

    // Operand conditioning: subtraction is a + ~b + 1.
    always_comb begin
`ifdef PIPELINED_ADDER_SUB_EN
        if (sub) begin
            b_eff_s   = ~b;
            cin_eff_s = 1'b1;
        end else begin
            b_eff_s   = b;
            cin_eff_s = cin;
        end
`else
        b_eff_s   = b;
        cin_eff_s = cin;
`endif
    end

    // Ready chain from the output back to the input.
    always_comb begin
        logic r;
        rdy_s = '0;
        r = !v_r[STAGES-1] || out_ready;
        rdy_s[STAGES-1] = r;
        for (int s = STAGES - 2; s >= 0; s--) begin
            r = !v_r[s] || r;
            rdy_s[s] = r;
        end
    end

    // Select what each stage would load: the input beat for stage 0, else the stage before.
    always_comb begin
        v_in_s = '0;
        c_in_s = '0;
        for (int s = 0; s < STAGES; s++) begin
            acc_in_s[s] = '0;
            bop_in_s[s] = '0;
        end
        v_in_s[0]   = in_valid;
        c_in_s[0]   = cin_eff_s;
        acc_in_s[0] = a;
        bop_in_s[0] = b_eff_s;
        for (int s = 1; s < STAGES; s++) begin
            v_in_s[s]   = v_r[s-1];
            c_in_s[s]   = c_r[s-1];
            acc_in_s[s] = acc_r[s-1];
            bop_in_s[s] = bop_r[s-1];
        end
    end

    // One W-bit ripple per stage; the result chunk replaces the consumed A chunk.
    always_comb begin
        c_nx_s = '0;
        for (int s = 0; s < STAGES; s++) begin
            part_s[s]   = {1'b0, W'(acc_in_s[s] >> (s * W))}
                        + {1'b0, W'(bop_in_s[s] >> (s * W))}
                        + {{W{1'b0}}, c_in_s[s]};
            acc_nx_s[s] = (acc_in_s[s] & ~chunk_mask(s))
                        | (K'(part_s[s][W-1:0]) << (s * W));
            c_nx_s[s]   = part_s[s][W];
        end
    end

    // Stage registers; data only moves with a valid beat so a stalled output holds steady.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_r <= '0;
            c_r <= '0;
            for (int s = 0; s < STAGES; s++) begin
                acc_r[s] <= '0;
                bop_r[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (rdy_s[s]) begin
                    v_r[s] <= v_in_s[s];
                    if (v_in_s[s]) begin
                        c_r[s]   <= c_nx_s[s];
                        acc_r[s] <= acc_nx_s[s];
                        bop_r[s] <= bop_in_s[s];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy_s[0];
    assign out_valid = v_r[STAGES-1];
    assign sum       = {c_r[STAGES-1], acc_r[STAGES-1]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed, table-driven bench for pipelined_adder (K=16, STAGES=4) plus a STAGES=1 instance.
module tb_pipelined_adder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [16:0] exp;
    } vec_t;

    typedef struct {
        logic [16:0] exp;
        int          acc_cyc;
    } sb_t;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] sum;

    logic        in_valid1;
    logic        in_ready1;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        cin1;
    logic        out_valid1;
    logic        out_ready1;
    logic [16:0] sum1;
`ifdef PIPELINED_ADDER_SUB_EN
    logic        sub;
    logic        sub1;
`endif

    int          checks;
    int          failures;
    int          cyc;
    bit          check_lat;
    bit          stall_prev;
    logic [16:0] stall_sum;
    sb_t         sb_q[$];
    vec_t        tbl[14];

    pipelined_adder #(.K(16), .STAGES(4)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
    );

    pipelined_adder #(.K(16), .STAGES(1)) dut1 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub(sub1),
`endif
        .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected bench completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 unit later, score the coming edge's transfers.
    task automatic cycle(input bit iv, input vec_t v, input bit ordy, output bit accepted);
        sb_t e;
        @(negedge clk);
        in_valid  = iv;
        a         = v.a;
        b         = v.b;
        cin       = v.cin;
`ifdef PIPELINED_ADDER_SUB_EN
        sub       = v.sub;
`endif
        out_ready = ordy;
        #1;
        accepted = iv && in_ready;
        if (stall_prev) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_sum", 32'(sum), 32'(stall_sum));
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got sum %h, expected no result", sum);
            end else begin
                e = sb_q.pop_front();
                check("result_sum", 32'(sum), 32'(e.exp));
                if (check_lat) check("latency", cyc - e.acc_cyc, 32'd4);
            end
        end
        stall_prev = out_valid && !out_ready;
        stall_sum  = sum;
        if (accepted) sb_q.push_back('{v.exp, cyc});
        cyc++;
    endtask

    task automatic drain(input string name);
        bit acc;
        for (int n = 0; n < 20 && sb_q.size() != 0; n++) cycle(1'b0, tbl[0], 1'b1, acc);
        check({name, "_drained"}, 32'(sb_q.size()), 32'd0);
        cycle(1'b0, tbl[0], 1'b1, acc);
        check({name, "_idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        bit   acc;
        int   idx;
        vec_t sv;

        tbl[0]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 17'h00000};
        tbl[1]  = '{16'h0001, 16'h1000, 1'b1, 1'b0, 17'h01002};
        tbl[2]  = '{16'h0002, 16'h2000, 1'b0, 1'b0, 17'h02002};
        tbl[3]  = '{16'h0003, 16'h3000, 1'b1, 1'b0, 17'h03004};
        tbl[4]  = '{16'h0004, 16'h4000, 1'b0, 1'b0, 17'h04004};
        tbl[5]  = '{16'h0005, 16'h5000, 1'b1, 1'b0, 17'h05006};
        tbl[6]  = '{16'h0006, 16'h6000, 1'b0, 1'b0, 17'h06006};
        tbl[7]  = '{16'h0007, 16'h7000, 1'b1, 1'b0, 17'h07008};
        tbl[8]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000};
        tbl[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF};
        tbl[10] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h00100};
        tbl[11] = '{16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 17'h10000};
        tbl[12] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 17'h05556};
        tbl[13] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000};

        checks = 0; failures = 0; cyc = 0;
        check_lat = 1'b1; stall_prev = 1'b0; stall_sum = 17'h00000;
        resetn = 1'b0; in_valid = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = 16'h0000; b1 = 16'h0000; cin1 = 1'b0; out_ready1 = 1'b1;
`ifdef PIPELINED_ADDER_SUB_EN
        sub = 1'b0; sub1 = 1'b0;
`endif

        @(negedge clk); #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_out_valid1", 32'(out_valid1), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Carry through every chunk boundary, exact 4-cycle latency.
        cycle(1'b1, tbl[8], 1'b1, acc);
        check("carry_accept", 32'(acc), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, tbl[0], 1'b1, acc);
            check("carry_no_early", 32'(out_valid), 32'd0);
        end
        drain("carry");

        // Back-to-back stream at full rate.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, tbl[i], 1'b1, acc);
            check("stream_in_ready", 32'(acc), 32'd1);
        end
        drain("stream");

        // Backpressure: only four beats fit, then full pass-through on release.
        check_lat = 1'b0;
        idx = 8;
        for (int n = 0; n < 8; n++) begin
            cycle(idx < 13, tbl[(idx < 13) ? idx : 12], 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_accepted", idx - 8, 32'd4);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        cycle(1'b1, tbl[idx], 1'b1, acc);
        check("full_pass_through", 32'(acc), 32'd1);
        if (acc) idx++;
        for (int n = 0; n < 20 && idx < 13; n++) begin
            cycle(1'b1, tbl[idx], 1'b1, acc);
            if (acc) idx++;
        end
        check("bp_all_sent", idx, 32'd13);
        drain("bp");

        // Bubble collapse with the output blocked.
        cycle(1'b1, tbl[0], 1'b0, acc);
        check("bubble_accept0", 32'(acc), 32'd1);
        cycle(1'b0, tbl[0], 1'b0, acc);
        cycle(1'b0, tbl[0], 1'b0, acc);
        cycle(1'b1, tbl[1], 1'b0, acc);
        check("bubble_accept1", 32'(acc), 32'd1);
        cycle(1'b1, tbl[2], 1'b0, acc);
        check("bubble_accept2", 32'(acc), 32'd1);
        cycle(1'b1, tbl[3], 1'b0, acc);
        check("bubble_accept3", 32'(acc), 32'd1);
        cycle(1'b1, tbl[4], 1'b0, acc);
        check("bubble_full", 32'(acc), 32'd0);
        drain("bubble");

        // Asynchronous reset with beats in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, tbl[i + 1], 1'b0, acc);
        cycle(1'b0, tbl[0], 1'b0, acc);
        cycle(1'b0, tbl[0], 1'b0, acc);
        check("pre_reset_out_valid", 32'(out_valid), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_sum", 32'(sum), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        sb_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int n = 0; n < 6; n++) begin
            cycle(1'b0, tbl[0], 1'b1, acc);
            check("no_stale", 32'(out_valid), 32'd0);
        end
        check_lat = 1'b1;
        cycle(1'b1, tbl[13], 1'b1, acc);
        check("after_reset_accept", 32'(acc), 32'd1);
        drain("after_reset");

`ifdef PIPELINED_ADDER_SUB_EN
        sv = '{16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE};
        cycle(1'b1, sv, 1'b1, acc);
        sv = '{16'h0007, 16'h0005, 1'b1, 1'b1, 17'h10002};
        cycle(1'b1, sv, 1'b1, acc);
        sv = '{16'h0007, 16'h0005, 1'b1, 1'b0, 17'h0000D};
        cycle(1'b1, sv, 1'b1, acc);
        drain("sub");
`else
        sv = '{16'h0007, 16'h0005, 1'b1, 1'b0, 17'h0000D};
        cycle(1'b1, sv, 1'b1, acc);
        drain("add_only");
`endif

        // Single-stage variant: one registered add.
        @(negedge clk);
        in_valid1 = 1'b1; a1 = 16'h0003; b1 = 16'h0004; cin1 = 1'b1;
        #1;
        check("s1_in_ready", 32'(in_ready1), 32'd1);
        check("s1_not_yet", 32'(out_valid1), 32'd0);
        @(negedge clk);
        in_valid1 = 1'b0;
        #1;
        check("s1_out_valid", 32'(out_valid1), 32'd1);
        check("s1_sum", 32'(sum1), 32'h00008);
`ifdef PIPELINED_ADDER_SUB_EN
        @(negedge clk);
        in_valid1 = 1'b1; a1 = 16'h0005; b1 = 16'h0007; cin1 = 1'b0; sub1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0; sub1 = 1'b0;
        #1;
        check("s1_sub_sum", 32'(sum1), 32'h0FFFE);
`endif
        @(negedge clk); #1;
        check("s1_idle", 32'(out_valid1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
